// File: rtl/hdlc_tx_loader_if.sv
// rtl/hdlc_tx_loader_if.sv - byte stream and HDLC register bus bundle for hdlc_tx_loader
interface hdlc_tx_loader_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;
    logic [2:0] Address;
    logic       WriteEnable;
    logic       ReadEnable;
    logic [7:0] DataIn;
    logic [7:0] DataOut;

    // loader side: consumes the byte stream, masters the register bus
    modport master (
        input  s_valid, s_data, s_last, DataOut,
        output s_ready, Address, WriteEnable, ReadEnable, DataIn
    );

    // environment side: byte source plus HDLC register file
    modport slave (
        output s_valid, s_data, s_last, DataOut,
        input  s_ready, Address, WriteEnable, ReadEnable, DataIn
    );
endinterface

// File: rtl/hdlc_tx_loader.sv
// rtl/hdlc_tx_loader.sv - loads a frame into the HDLC Tx buffer, starts it and polls for completion
module hdlc_tx_loader #(
    parameter int MAX_BYTES = 126,
    parameter int POLL_GAP  = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    hdlc_tx_loader_if.master bus,
    input  logic             abort_req,
    output logic             busy,
    output logic             frame_sent,
    output logic             frame_aborted,
    output logic             overflow_err,
    output logic [6:0]       byte_cnt
);
    typedef enum logic [2:0] {
        IDLE, LOAD, START, GAP, POLL, SAMPLE, ABORT, DRAIN
    } state_t;

    localparam int GapW = (POLL_GAP < 1) ? 1 : $clog2(POLL_GAP + 1);
    // The write issued on leaving START/ABORT occupies the first GAP cycle,
    // so those entries count one extra cycle; re-polls from SAMPLE do not.
    localparam logic [GapW-1:0] GapFirst  = GapW'(POLL_GAP);
    localparam logic [GapW-1:0] GapNext   = GapW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam logic [6:0]      MaxCnt    = 7'(MAX_BYTES);
    localparam logic [2:0]      AddrSc    = 3'd0;
    localparam logic [2:0]      AddrBuff  = 3'd1;
    localparam logic [7:0]      CmdEnable = 8'h02;
    localparam logic [7:0]      CmdAbort  = 8'h04;

    state_t          state;
    logic [GapW-1:0] gapCnt;
    logic            take;

    assign take = bus.s_valid && bus.s_ready;

    // frame sequencer; every output is a register updated alongside the state
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state            <= IDLE;
            gapCnt           <= '0;
            bus.s_ready      <= 1'b0;
            bus.Address      <= 3'd0;
            bus.WriteEnable  <= 1'b0;
            bus.ReadEnable   <= 1'b0;
            bus.DataIn       <= 8'd0;
            busy             <= 1'b0;
            frame_sent       <= 1'b0;
            frame_aborted    <= 1'b0;
            overflow_err     <= 1'b0;
            byte_cnt         <= 7'd0;
        end else begin
            bus.WriteEnable <= 1'b0;
            bus.ReadEnable  <= 1'b0;
            bus.Address     <= 3'd0;
            bus.DataIn      <= 8'd0;
            frame_sent      <= 1'b0;
            frame_aborted   <= 1'b0;
            case (state)
                IDLE: begin
                    bus.s_ready <= 1'b1;
                    if (take) begin
                        bus.WriteEnable <= 1'b1;
                        bus.Address     <= AddrBuff;
                        bus.DataIn      <= bus.s_data;
                        byte_cnt        <= 7'd1;
                        overflow_err    <= 1'b0;
                        busy            <= 1'b1;
                        if (bus.s_last) begin
                            state       <= START;
                            bus.s_ready <= 1'b0;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (abort_req) begin
                        // a byte carrying s_last in the abort cycle already closes the frame
                        if (take && bus.s_last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (take) begin
                        if (byte_cnt == MaxCnt && !bus.s_last) begin
                            overflow_err <= 1'b1;
                            state        <= DRAIN;
                        end else begin
                            bus.WriteEnable <= 1'b1;
                            bus.Address     <= AddrBuff;
                            bus.DataIn      <= bus.s_data;
                            byte_cnt        <= byte_cnt + 7'd1;
                            if (bus.s_last) begin
                                state       <= START;
                                bus.s_ready <= 1'b0;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (take && bus.s_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                START: begin
                    if (abort_req) begin
                        state <= ABORT;
                    end else begin
                        bus.WriteEnable <= 1'b1;
                        bus.Address     <= AddrSc;
                        bus.DataIn      <= CmdEnable;
                        gapCnt          <= GapFirst;
                        state           <= GAP;
                    end
                end
                GAP: begin
                    if (abort_req) begin
                        state <= ABORT;
                    end else if (gapCnt == '0) begin
                        bus.ReadEnable <= 1'b1;
                        bus.Address    <= AddrSc;
                        state          <= POLL;
                    end else begin
                        gapCnt <= gapCnt - GapW'(1);
                    end
                end
                POLL: begin
                    state <= abort_req ? ABORT : SAMPLE;
                end
                SAMPLE: begin
                    if (abort_req) begin
                        state <= ABORT;
                    end else if (bus.DataOut[3]) begin
                        frame_aborted <= 1'b1;
                        busy          <= 1'b0;
                        bus.s_ready   <= 1'b1;
                        state         <= IDLE;
                    end else if (bus.DataOut[0]) begin
                        frame_sent  <= 1'b1;
                        busy        <= 1'b0;
                        bus.s_ready <= 1'b1;
                        state       <= IDLE;
                    end else if (POLL_GAP == 0) begin
                        bus.ReadEnable <= 1'b1;
                        bus.Address    <= AddrSc;
                        state          <= POLL;
                    end else begin
                        gapCnt <= GapNext;
                        state  <= GAP;
                    end
                end
                ABORT: begin
                    bus.WriteEnable <= 1'b1;
                    bus.Address     <= AddrSc;
                    bus.DataIn      <= CmdAbort;
                    gapCnt          <= GapFirst;
                    state           <= GAP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hdlc_tx_loader.sv
// tb/tb_hdlc_tx_loader.sv - bench for hdlc_tx_loader against a bus-timing reference model
module tb_hdlc_tx_loader;
    localparam int MaxBytes = 126;
    localparam int PollGap  = 4;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       abort_req = 1'b0;
    logic       busy, frame_sent, frame_aborted, overflow_err;
    logic [6:0] byte_cnt;

    hdlc_tx_loader_if bus ();

    hdlc_tx_loader #(.MAX_BYTES(MaxBytes), .POLL_GAP(PollGap)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .bus          (bus),
        .abort_req    (abort_req),
        .busy         (busy),
        .frame_sent   (frame_sent),
        .frame_aborted(frame_aborted),
        .overflow_err (overflow_err),
        .byte_cnt     (byte_cnt)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [31:0] wpack(input int c, input logic [2:0] a, input logic [7:0] d);
        logic [31:0] cv;
        cv = c;
        return {cv[20:0], a, d};
    endfunction

    // bus observations, plus the register-file read responder
    logic [31:0] wq[$];
    int          rq[$];
    int          sentQ[$];
    int          abortQ[$];
    int          ovQ[$];
    int          busyCyc = 0;
    int          pv = 0;
    int          monIdx;
    logic        ovPrev = 1'b0;
    logic [7:0]  respArr[$];
    int          rBase = 0;

    always @(negedge Clk) begin
        if (!Rst) bus.DataOut = 8'h00;
        if (bus.WriteEnable) wq.push_back(wpack(cyc, bus.Address, bus.DataIn));
        if (bus.ReadEnable) begin
            monIdx = rq.size() - rBase;
            bus.DataOut = (monIdx < respArr.size()) ? respArr[monIdx] : 8'h00;
            rq.push_back(cyc);
        end
        if (frame_sent) sentQ.push_back(cyc);
        if (frame_aborted) abortQ.push_back(cyc);
        if (busy) busyCyc++;
        if (overflow_err && !ovPrev) ovQ.push_back(cyc);
        ovPrev = overflow_err;
        if (bus.WriteEnable && bus.ReadEnable) pv++;
        if (!bus.WriteEnable && !bus.ReadEnable && (bus.Address != 3'd0 || bus.DataIn != 8'd0)) pv++;
    end

    int          checks = 0;
    int          errors = 0;
    int          wBase, sBase, aBase, bBase, pBase;
    int          acc[$];
    logic [31:0] ew[$];
    int          er[$];
    int          eSent, eAbort;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic begin_test();
        wBase = wq.size();
        rBase = rq.size();
        sBase = sentQ.size();
        aBase = abortQ.size();
        bBase = busyCyc;
        pBase = pv;
        acc.delete();
        ew.delete();
        er.delete();
        respArr.delete();
        eSent = 0;
        eAbort = 0;
    endtask

    // called at a falling edge; returns at the falling edge after the handshake
    task automatic send_byte(input logic [7:0] d, input logic last);
        int t = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        while (!bus.s_ready && t < 200) begin
            @(negedge Clk);
            t++;
        end
        chk("handshake wait", (t < 200), 1);
        acc.push_back(cyc);
        @(negedge Clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] fr[$], input bit gaps);
        for (int i = 0; i < fr.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge Clk);
            send_byte(fr[i], (i == fr.size() - 1));
        end
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (busy === 1'b1 && t < 3000) begin
            @(negedge Clk);
            t++;
        end
        chk({tag, " done"}, (t < 3000), 1);
        repeat (2) @(negedge Clk);
    endtask

    // reads start POLL_GAP+1 after the Tx_SC write and repeat every POLL_GAP+2
    // until a response shows aborted (bit 3, checked first) or done (bit 0)
    task automatic add_polls(input int w);
        logic [7:0] r;
        for (int j = 0; j < respArr.size(); j++) begin
            r = respArr[j];
            er.push_back(w + PollGap + 1 + j * (PollGap + 2));
            if (r[3]) begin
                eAbort = 1;
                break;
            end
            if (r[0]) begin
                eSent = 1;
                break;
            end
        end
    endtask

    // every accepted byte is on the bus the next cycle, START write one cycle after the last
    task automatic build_normal(input logic [7:0] fr[$]);
        int w;
        for (int i = 0; i < fr.size(); i++) ew.push_back(wpack(acc[i] + 1, 3'd1, fr[i]));
        w = acc[acc.size() - 1] + 2;
        ew.push_back(wpack(w, 3'd0, 8'h02));
        add_polls(w);
    endtask

    task automatic check_frame(input string tag, input int expCnt, input logic expOv);
        int n;
        n = wq.size() - wBase;
        chk({tag, " nwr"}, n, ew.size());
        for (int i = 0; i < ew.size() && i < n; i++)
            chk($sformatf("%s wr%0d", tag, i), wq[wBase + i], ew[i]);
        n = rq.size() - rBase;
        chk({tag, " nrd"}, n, er.size());
        for (int i = 0; i < er.size() && i < n; i++)
            chk($sformatf("%s rd%0d", tag, i), rq[rBase + i], er[i]);
        chk({tag, " sent"}, sentQ.size() - sBase, eSent);
        chk({tag, " aborted"}, abortQ.size() - aBase, eAbort);
        chk({tag, " byte_cnt"}, byte_cnt, expCnt);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " overflow"}, overflow_err, expOv);
        chk({tag, " bus rules"}, pv - pBase, 0);
    endtask

    initial begin
        logic [7:0] fr[$];
        logic [7:0] last;
        int         w, k, len, pick;

        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_last  = 1'b0;

        // reset values
        repeat (2) @(negedge Clk);
        chk("rst s_ready", bus.s_ready, 0);
        chk("rst we", bus.WriteEnable, 0);
        chk("rst re", bus.ReadEnable, 0);
        chk("rst addr", bus.Address, 0);
        chk("rst din", bus.DataIn, 0);
        chk("rst busy", busy, 0);
        chk("rst sent", frame_sent, 0);
        chk("rst aborted", frame_aborted, 0);
        chk("rst ovf", overflow_err, 0);
        chk("rst byte_cnt", byte_cnt, 0);
        Rst = 1'b1;
        #1 chk("release s_ready", bus.s_ready, 0);
        @(negedge Clk);
        chk("first clk s_ready", bus.s_ready, 1);

        // 1-byte frame, done on first poll
        begin_test();
        respArr.push_back(8'h01);
        fr = '{8'hA5};
        send_frame(fr, 1'b0);
        wait_idle("one");
        build_normal(fr);
        check_frame("one", 1, 1'b0);
        chk("one busy len", busyCyc - bBase, PollGap + 4);
        chk("one sent cyc", (sentQ.size() > sBase) ? sentQ[sBase] : -1, acc[0] + PollGap + 5);

        // full-size frame, three not-done polls
        begin_test();
        fr.delete();
        for (int i = 0; i < MaxBytes; i++) fr.push_back(8'(i));
        respArr = '{8'h00, 8'h00, 8'h00, 8'h01};
        send_frame(fr, 1'b0);
        wait_idle("full");
        build_normal(fr);
        check_frame("full", MaxBytes, 1'b0);
        chk("full contiguous", acc[MaxBytes - 1] - acc[0], MaxBytes - 1);

        // overflow: 130 bytes, only the first MaxBytes reach the buffer
        begin_test();
        fr.delete();
        for (int i = 0; i < 130; i++) fr.push_back(8'($urandom));
        send_frame(fr, 1'b0);
        wait_idle("ovf");
        for (int i = 0; i < MaxBytes; i++) ew.push_back(wpack(acc[i] + 1, 3'd1, fr[i]));
        check_frame("ovf", MaxBytes, 1'b1);
        chk("ovf rise cyc", (ovQ.size() > 0) ? ovQ[ovQ.size() - 1] : -1, acc[MaxBytes] + 1);
        chk("ovf ready held", acc[129] - acc[0], 129);

        // abort while waiting in GAP
        begin_test();
        fr.delete();
        for (int i = 0; i < 10; i++) fr.push_back(8'($urandom));
        respArr.push_back(8'h08);
        send_frame(fr, 1'b0);
        w = acc[9] + 2;
        while (cyc < w + 1) @(negedge Clk);
        abort_req = 1'b1;
        @(negedge Clk);
        abort_req = 1'b0;
        wait_idle("agap");
        for (int i = 0; i < 10; i++) ew.push_back(wpack(acc[i] + 1, 3'd1, fr[i]));
        ew.push_back(wpack(w, 3'd0, 8'h02));
        ew.push_back(wpack(w + 3, 3'd0, 8'h04));
        add_polls(w + 3);
        check_frame("agap", 10, 1'b0);

        // abort during LOAD: partial frame dropped, remaining bytes drained
        begin_test();
        fr.delete();
        for (int i = 0; i < 8; i++) fr.push_back(8'($urandom));
        for (int i = 0; i < 5; i++) send_byte(fr[i], 1'b0);
        abort_req = 1'b1;
        @(negedge Clk);
        abort_req = 1'b0;
        for (int i = 5; i < 8; i++) send_byte(fr[i], (i == 7));
        wait_idle("aload");
        for (int i = 0; i < 5; i++) ew.push_back(wpack(acc[i] + 1, 3'd1, fr[i]));
        check_frame("aload", 5, 1'b0);

        // asynchronous reset in the middle of LOAD
        begin_test();
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
        #2 Rst = 1'b0;
        #1;
        chk("mid rst s_ready", bus.s_ready, 0);
        chk("mid rst we", bus.WriteEnable, 0);
        chk("mid rst addr", bus.Address, 0);
        chk("mid rst din", bus.DataIn, 0);
        chk("mid rst busy", busy, 0);
        chk("mid rst byte_cnt", byte_cnt, 0);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        begin_test();
        respArr.push_back(8'h01);
        fr = '{8'h3C};
        send_frame(fr, 1'b0);
        wait_idle("after rst");
        build_normal(fr);
        check_frame("after rst", 1, 1'b0);

        // randomized frames with idle gaps and random poll sequences
        for (int f = 0; f < 6; f++) begin
            begin_test();
            len = $urandom_range(1, 20);
            fr.delete();
            for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
            k = $urandom_range(1, 4);
            for (int j = 0; j < k - 1; j++) respArr.push_back(8'($urandom) & 8'hF6);
            pick = $urandom_range(0, 2);
            last = (8'($urandom) & 8'hF6) | ((pick == 0) ? 8'h01 : (pick == 1) ? 8'h08 : 8'h09);
            respArr.push_back(last);
            send_frame(fr, 1'b1);
            wait_idle($sformatf("rnd%0d", f));
            build_normal(fr);
            check_frame($sformatf("rnd%0d", f), len, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
